// File: rtl/ibus_pkg.sv
// ibus_pkg: shared types and reset constants for the instruction-side
// responder (ibus_responder) and its last-fetch hit buffer (ibus_hit_buf).
//   ibus_state_t : responder FSM encoding (IDLE, REQ, WAIT)
//   ibus_req_t   : fetch request bundle {valid, addr} at default widths
//   ibus_resp_t  : fetch response bundle {valid, data} at default widths
//   BUF_*_RST    : reset contents of the last-fetch buffer
package ibus_pkg;

  localparam int IBUS_ADDR_W = 32;
  localparam int IBUS_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } ibus_state_t;

  typedef struct packed {
    logic                   valid;
    logic [IBUS_ADDR_W-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic                   valid;
    logic [IBUS_DATA_W-1:0] data;
  } ibus_resp_t;

  localparam logic                   BUF_VALID_RST = 1'b0;
  localparam logic [IBUS_ADDR_W-1:0] BUF_ADDR_RST  = '0;
  localparam logic [IBUS_DATA_W-1:0] BUF_DATA_RST  = '0;

endpackage

// File: rtl/ibus_responder_if.sv
// ibus_responder_if: single-outstanding memory read bus between the
// instruction responder and the instruction memory / cache port.
//   mem_req_valid  : read request (held until accepted)
//   mem_req_addr   : word-aligned request address, stable while valid
//   mem_req_ready  : memory accepts the request this cycle
//   mem_resp_valid : read data valid
//   mem_resp_data  : read data
// master = responder side, slave = memory side.
interface ibus_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data
  );

endinterface

// File: rtl/ibus_hit_buf.sv
// ibus_hit_buf: one-entry last-fetch buffer.
//   clk, resetn   : clock, asynchronous active-low reset
//   fill          : load fill_addr/fill_data and mark the entry valid
//   fill_addr/data: address and instruction word being loaded
//   inv           : invalidate the entry (a coincident fill wins)
//   lookup_addr   : address to compare against the stored entry
//   hit           : entry valid and address matches (forced 0 when BUF_EN=0)
//   data          : stored instruction word
module ibus_hit_buf
  import ibus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BUF_EN = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inv,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid <= BUF_VALID_RST;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (fill) begin
      buf_valid <= 1'b1;
      buf_addr  <= fill_addr;
      buf_data  <= fill_data;
    end else if (inv) begin
      buf_valid <= 1'b0;
    end
  end

  assign hit  = (BUF_EN != 0) && buf_valid && (buf_addr == lookup_addr);
  assign data = buf_data;

endmodule

// File: rtl/ibus_responder.sv
// ibus_responder: instruction-side responder for the fetch stage.
// Serves fetch requests from a one-entry last-fetch buffer when possible,
// otherwise issues a single outstanding read on the memory bus.
//   clk, resetn  : clock, asynchronous active-low reset
//   ireq_valid   : fetch requests an instruction at ireq_addr
//   ireq_addr    : translated fetch PC
//   flush        : pipeline redirect, discard any in-flight fetch
//   buf_inv      : invalidate the last-fetch buffer
//   iresp_valid  : iresp_data valid for the current ireq_addr
//   iresp_data   : raw instruction (0 for a misaligned request)
//   istall       : fetch must hold its PC this cycle
//   mem          : memory request/response bus (master side)
module ibus_responder
  import ibus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BUF_EN = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  input  logic              flush,
  input  logic              buf_inv,
  output logic              iresp_valid,
  output logic [DATA_W-1:0] iresp_data,
  output logic              istall,
  ibus_responder_if.master  mem
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_WAIT = WAIT;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pend_addr;
  logic              drop;

  logic              misaligned;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              fill;
  logic              miss_go;

  assign misaligned = ireq_valid & (|ireq_addr[1:0]);

  // A flush arriving together with the response also discards it.
  assign fill = (state == S_WAIT) & mem.mem_resp_valid & ~drop & ~flush;

  assign miss_go = ireq_valid & ~misaligned & ~hit & ~flush;

  ibus_hit_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BUF_EN (BUF_EN)
  ) u_hit_buf (
    .clk         (clk),
    .resetn      (resetn),
    .fill        (fill),
    .fill_addr   (pend_addr),
    .fill_data   (mem.mem_resp_data),
    .inv         (buf_inv),
    .lookup_addr (ireq_addr),
    .hit         (hit),
    .data        (hit_data)
  );

  // Responses are only produced while no memory transaction is in flight.
  always_comb begin
    iresp_valid = 1'b0;
    iresp_data  = '0;
    if (state == S_IDLE) begin
      iresp_valid = ireq_valid & (misaligned | hit);
      iresp_data  = hit ? hit_data : '0;
    end
  end

  assign istall            = ireq_valid & ~iresp_valid;
  assign mem.mem_req_valid = (state == S_REQ);
  assign mem.mem_req_addr  = (state == S_REQ) ? pend_addr : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      pend_addr <= '0;
      drop      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss_go) begin
            pend_addr <= ireq_addr;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          // Once accepted the transaction must complete; a flush in the
          // accept cycle only marks the data for discard.
          if (mem.mem_req_ready) begin
            state <= S_WAIT;
            drop  <= flush;
          end else if (flush) begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (mem.mem_resp_valid) begin
            drop  <= 1'b0;
            state <= S_IDLE;
          end else if (flush) begin
            drop <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibus_responder.sv
// tb_ibus_responder: directed bench for ibus_responder with hand-computed
// expected values, checked by immediate assertions.
module tb_ibus_responder;

  logic        clk;
  logic        resetn;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        flush;
  logic        buf_inv;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        istall;

  int checks;
  int errors;

  ibus_responder_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  ibus_responder #(
    .ADDR_W (32),
    .DATA_W (32),
    .BUF_EN (1)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ireq_valid  (ireq_valid),
    .ireq_addr   (ireq_addr),
    .flush       (flush),
    .buf_inv     (buf_inv),
    .iresp_valid (iresp_valid),
    .iresp_data  (iresp_data),
    .istall      (istall),
    .mem         (mem_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, inputs are driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  task automatic chk_idle_out(input string tag, input logic ivld, input logic [31:0] idata,
                              input logic stall, input logic mvld);
    chk({tag, ".iresp_valid"}, {31'd0, iresp_valid}, {31'd0, ivld});
    chk({tag, ".iresp_data"}, iresp_data, idata);
    chk({tag, ".istall"}, {31'd0, istall}, {31'd0, stall});
    chk({tag, ".mem_req_valid"}, {31'd0, mem_if.mem_req_valid}, {31'd0, mvld});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    ireq_valid = 1'b0;
    ireq_addr = 32'h0;
    flush = 1'b0;
    buf_inv = 1'b0;
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_resp_valid = 1'b0;
    mem_if.mem_resp_data = 32'h0;

    // Reset state
    tick();
    tick();
    chk_idle_out("rst", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst.mem_req_addr", mem_if.mem_req_addr, 32'h0);
    resetn = 1'b1;
    tick();
    chk_idle_out("post_rst", 1'b0, 32'h0, 1'b0, 1'b0);

    // Minimum-latency miss: cycles 0..3
    ireq_valid = 1'b1;
    ireq_addr = 32'hBFC0_0000;
    mem_if.mem_req_ready = 1'b1;
    settle();
    chk_idle_out("miss.c0", 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    settle();
    chk("miss.c1.mem_req_valid", {31'd0, mem_if.mem_req_valid}, 32'd1);
    chk("miss.c1.mem_req_addr", mem_if.mem_req_addr, 32'hBFC0_0000);
    chk("miss.c1.istall", {31'd0, istall}, 32'd1);
    tick();
    mem_if.mem_resp_valid = 1'b1;
    mem_if.mem_resp_data = 32'h3C08_BFC0;
    settle();
    chk_idle_out("miss.c2", 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    mem_if.mem_resp_valid = 1'b0;
    mem_if.mem_resp_data = 32'h0;
    settle();
    chk_idle_out("miss.c3", 1'b1, 32'h3C08_BFC0, 1'b0, 1'b0);

    // Same address held: served from the buffer every cycle
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      chk_idle_out("hold_hit", 1'b1, 32'h3C08_BFC0, 1'b0, 1'b0);
    end

    // Misaligned: immediate response with zero data, never reaches memory
    ireq_addr = 32'hBFC0_0002;
    settle();
    chk_idle_out("misal.c0", 1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    settle();
    chk_idle_out("misal.c1", 1'b1, 32'h0, 1'b0, 1'b0);

    // Request held off by mem_req_ready, then aborted by flush
    mem_if.mem_req_ready = 1'b0;
    ireq_addr = 32'h8000_0004;
    settle();
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_req.valid", {31'd0, mem_if.mem_req_valid}, 32'd1);
      chk("stall_req.addr", mem_if.mem_req_addr, 32'h8000_0004);
      tick();
    end
    flush = 1'b1;
    ireq_addr = 32'h8000_0000;
    settle();
    chk("abort.valid", {31'd0, mem_if.mem_req_valid}, 32'd1);
    chk("abort.addr", mem_if.mem_req_addr, 32'h8000_0004);
    tick();
    flush = 1'b0;
    settle();
    chk_idle_out("abort.idle", 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    settle();
    chk("new_req.valid", {31'd0, mem_if.mem_req_valid}, 32'd1);
    chk("new_req.addr", mem_if.mem_req_addr, 32'h8000_0000);
    mem_if.mem_req_ready = 1'b1;
    tick();
    mem_if.mem_resp_valid = 1'b1;
    mem_if.mem_resp_data = 32'h1111_2222;
    tick();
    mem_if.mem_resp_valid = 1'b0;
    settle();
    chk_idle_out("new_req.hit", 1'b1, 32'h1111_2222, 1'b0, 1'b0);

    // Flush in WAIT: response dropped, old address refetched
    ireq_addr = 32'h8000_0008;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    chk("drop.wait_istall", {31'd0, istall}, 32'd1);
    tick();
    mem_if.mem_resp_valid = 1'b1;
    mem_if.mem_resp_data = 32'hDEAD_BEEF;
    tick();
    mem_if.mem_resp_valid = 1'b0;
    settle();
    chk_idle_out("drop.nofill", 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    settle();
    chk("drop.refetch.valid", {31'd0, mem_if.mem_req_valid}, 32'd1);
    chk("drop.refetch.addr", mem_if.mem_req_addr, 32'h8000_0008);
    tick();
    // Fill coincident with buf_inv: the fill wins
    mem_if.mem_resp_valid = 1'b1;
    mem_if.mem_resp_data = 32'hCAFE_F00D;
    buf_inv = 1'b1;
    tick();
    mem_if.mem_resp_valid = 1'b0;
    buf_inv = 1'b0;
    settle();
    chk_idle_out("fill_vs_inv", 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);

    // buf_inv after a fill forces a reissue
    ireq_addr = 32'h8000_0010;
    tick();
    tick();
    mem_if.mem_resp_valid = 1'b1;
    mem_if.mem_resp_data = 32'h1234_5678;
    tick();
    mem_if.mem_resp_valid = 1'b0;
    settle();
    chk_idle_out("inv.filled", 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    buf_inv = 1'b1;
    tick();
    buf_inv = 1'b0;
    settle();
    chk_idle_out("inv.miss", 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    settle();
    chk("inv.reissue.valid", {31'd0, mem_if.mem_req_valid}, 32'd1);
    chk("inv.reissue.addr", mem_if.mem_req_addr, 32'h8000_0010);
    tick();

    // Reset asserted in WAIT, then a late response is ignored
    ireq_valid = 1'b0;
    resetn = 1'b0;
    settle();
    chk_idle_out("rst_wait", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_wait.mem_req_addr", mem_if.mem_req_addr, 32'h0);
    tick();
    resetn = 1'b1;
    mem_if.mem_resp_valid = 1'b1;
    mem_if.mem_resp_data = 32'h5555_AAAA;
    tick();
    mem_if.mem_resp_valid = 1'b0;
    ireq_valid = 1'b1;
    settle();
    chk_idle_out("late_resp", 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    settle();
    chk("late_resp.req.valid", {31'd0, mem_if.mem_req_valid}, 32'd1);
    chk("late_resp.req.addr", mem_if.mem_req_addr, 32'h8000_0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
